// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs in, per-stage enable/flush/bubble controls out.
// Controls are combinational from state and inputs; no handshake or backpressure inside the bundle.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  ex_MemRead;
    logic                  ex_RegWrite;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  stall_clr;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  mem_wb_bubble;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cnt;
    logic [1:0]            state;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_RegWrite, ex_rd,
               branch_taken, mem_req, mem_ready, stall_clr,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout, stall_cnt, state
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_RegWrite, ex_rd,
               branch_taken, mem_req, mem_ready, stall_clr,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout, stall_cnt, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, multi-cycle memory with timeout.
// Controls are combinational (zero latency); a pending memory access freezes all five stages.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t     w_state_nxt;
    logic [7:0] w_wait_nxt;
    logic       w_timeout_nxt;
    logic       w_load_use;
    logic       w_flow;
    logic       w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic       w_if_id_flush, w_id_ex_flush, w_mem_wb_bubble;

    assign w_load_use = bus.ex_MemRead & bus.ex_RegWrite & (bus.ex_rd != ZERO_REG) &
                        ((bus.ex_rd == bus.id_rs) | (bus.id_uses_rt & (bus.ex_rd == bus.id_rt)));

    // Pipeline may advance only when no data-memory access is outstanding.
    assign w_flow = ((r_state == ST_RUN)  & ~(bus.mem_req & ~bus.mem_ready)) |
                    ((r_state == ST_WAIT) & bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_mem_timeout <= w_timeout_nxt;
            if (bus.stall_clr)
                r_stall_cnt <= '0;
            else if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_nxt = r_mem_timeout;
        case (r_state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_state_nxt = ST_WAIT;
                    w_wait_nxt  = 8'd1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = 8'd0;
                end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
                    w_state_nxt   = ST_ERR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait_cnt + 8'd1;
                end
            end
            ST_ERR: w_timeout_nxt = 1'b1;
            default: begin
                w_state_nxt   = ST_ERR;
                w_timeout_nxt = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_pc_en         = 1'b0;
        w_if_id_en      = 1'b0;
        w_id_ex_en      = 1'b0;
        w_ex_mem_en     = 1'b0;
        w_mem_wb_en     = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            w_mem_wb_bubble = 1'b0;
        end else if (!w_flow) begin
            w_mem_wb_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            // Squashing ID makes any concurrent load-use irrelevant.
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            {w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 3'b111;
            w_id_ex_flush = 1'b1;
        end else begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
        end
    end

    assign bus.pc_en         = w_pc_en;
    assign bus.if_id_en      = w_if_id_en;
    assign bus.id_ex_en      = w_id_ex_en;
    assign bus.ex_mem_en     = w_ex_mem_en;
    assign bus.mem_wb_en     = w_mem_wb_en;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_flush   = w_id_ex_flush;
    assign bus.mem_wb_bubble = w_mem_wb_bubble;
    assign bus.mem_timeout   = r_mem_timeout;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(3), .CNT_W(16)) bus ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0=running, 1=waiting on memory, 2=error
    int m_state = 0;
    int m_wait  = 0;
    int m_stall = 0;
    int m_to    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hazard_lu();
        return bus.ex_MemRead && bus.ex_RegWrite && (bus.ex_rd != 0) &&
               ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && bus.ex_rd == bus.id_rt));
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush, mem_wb_bubble}
    function automatic logic [7:0] exp_ctrl();
        bit mem_blocked;
        if (!rst_n) return 8'h00;
        mem_blocked = (m_state == 2) ||
                      (m_state == 0 && bus.mem_req && !bus.mem_ready) ||
                      (m_state == 1 && !bus.mem_ready);
        if (mem_blocked)       return 8'b00000_001;
        if (bus.branch_taken)  return 8'b11111_110;
        if (hazard_lu())       return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            m_state = 0; m_wait = 0; m_stall = 0; m_to = 0;
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit uses, input bit mr, input bit rw,
                          input int rd, input bit br, input bit req, input bit rdy, input bit clr);
        bus.id_rs        = 3'(rs);
        bus.id_rt        = 3'(rt);
        bus.id_uses_rt   = uses;
        bus.ex_MemRead   = mr;
        bus.ex_RegWrite  = rw;
        bus.ex_rd        = 3'(rd);
        bus.branch_taken = br;
        bus.mem_req      = req;
        bus.mem_ready    = rdy;
        bus.stall_clr    = clr;
    endtask

    task automatic set_idle(input bit clr);
        set_in(1, 2, 1, 0, 0, 0, 0, 0, 1, clr);
    endtask

    // Check outputs mid-cycle, then advance the model at the clock edge.
    task automatic step(input string tag);
        logic [7:0] e;
        @(negedge clk);
        e = exp_ctrl();
        chk({tag, "_ctrl"}, 32'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                                bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble}), 32'(e));
        chk({tag, "_state"}, 32'(bus.state), 32'(m_state));
        chk({tag, "_tmo"}, 32'(bus.mem_timeout), 32'(m_to));
        chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
        @(posedge clk);
        if (rst_n) begin
            if (bus.stall_clr)               m_stall = 0;
            else if (!e[7] && m_stall < 65535) m_stall++;
            if (m_state == 0) begin
                if (bus.mem_req && !bus.mem_ready) begin m_state = 1; m_wait = 1; end
            end else if (m_state == 1) begin
                if (bus.mem_ready)         begin m_state = 0; m_wait = 0; end
                else if (m_wait == TO)     begin m_state = 2; m_to = 1; end
                else                       m_wait++;
            end
        end
        #1;
    endtask

    initial begin
        // Reset forces controls low even with active hazard inputs.
        set_rst(1'b0);
        set_in(3, 3, 1, 1, 1, 3, 1, 1, 0, 0);
        step("rst");
        step("rst2");
        set_rst(1'b1);
        set_idle(0);
        step("idle");

        // Load-use on rs: one-cycle stall.
        set_idle(1); step("clr0");
        set_in(3, 1, 1, 1, 1, 3, 0, 0, 1, 0); step("lu_rs");
        chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        set_in(3, 1, 1, 0, 1, 4, 0, 0, 1, 0); step("lu_after");

        // Load-use on rt, then the two non-hazard cases.
        set_in(1, 6, 1, 1, 1, 6, 0, 0, 1, 0); step("lu_rt");
        set_in(0, 2, 1, 1, 1, 0, 0, 0, 1, 0); step("rd0");
        set_in(1, 5, 0, 1, 1, 5, 0, 0, 1, 0); step("rt_unused");
        set_in(1, 5, 1, 1, 0, 5, 0, 0, 1, 0); step("no_regwrite");

        // Branch hides load-use.
        set_idle(1); step("clr1");
        set_in(3, 3, 1, 1, 1, 3, 1, 0, 1, 0); step("br_lu");
        chk("br_lu_cnt", 32'(bus.stall_cnt), 32'd0);

        // Zero-wait access then three-cycle memory stall.
        set_in(1, 2, 1, 0, 0, 0, 0, 1, 1, 0); step("mem_zw");
        for (int i = 0; i < 3; i++) begin
            set_in(1, 2, 1, 0, 0, 0, 0, 1, 0, 0); step("mem_wait");
        end
        set_in(1, 2, 1, 0, 0, 0, 0, 1, 1, 0); step("mem_done");
        chk("mem_cnt", 32'(bus.stall_cnt), 32'd3);
        chk("mem_back", 32'(bus.state), 32'd0);

        // Load-use while memory completes.
        set_in(1, 1, 1, 0, 0, 0, 0, 1, 0, 0); step("mem_lu_w");
        set_in(2, 1, 1, 1, 1, 2, 0, 1, 1, 0); step("mem_lu_done");

        // Reset mid-wait aborts immediately.
        set_in(1, 2, 1, 0, 0, 0, 0, 1, 0, 0); step("abort_w");
        set_rst(1'b0);
        #1 chk("abort_state", 32'(bus.state), 32'd0);
        step("abort_rst");
        set_rst(1'b1);

        // Timeout: ERR after TO+1 edges, sticky.
        for (int i = 0; i < TO + 1; i++) begin
            set_in(1, 2, 1, 0, 0, 0, 0, 1, 0, 0); step("tmo_wait");
            if (i == TO - 1) chk("tmo_before", 32'(bus.state), 32'd1);
        end
        chk("tmo_state", 32'(bus.state), 32'd2);
        chk("tmo_flag", 32'(bus.mem_timeout), 32'd1);
        set_in(1, 2, 1, 0, 0, 0, 1, 1, 1, 0); step("err_hold");
        set_idle(0); step("err_hold2");

        // Saturation while stuck in ERR, then clear beats increment.
        repeat (65540) @(posedge clk);
        #1;
        m_stall = 65535;
        chk("sat", 32'(bus.stall_cnt), 32'hFFFF);
        set_idle(1); step("sat_clr");
        chk("sat_clr_cnt", 32'(bus.stall_cnt), 32'd0);

        set_rst(1'b0);
        set_idle(0);
        step("rst_err");
        set_rst(1'b1);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_tmo", 32'(bus.mem_timeout), 32'd0);
        chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 4) != 0,
                   ($urandom % 50) == 0);
            if (($urandom % 300) == 0) set_rst(1'b0);
            step("rnd");
            set_rst(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 16-bit MIPS 5-stage pipeline. It drives the load-enable, flush and bubble controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three conditions: load-use hazards, taken branches, and multi-cycle data-memory accesses. It also detects memory timeouts and keeps a saturating stall-cycle counter for debug.

Parameters:
REG_ADDR_W, 3, register-address width (8-entry register file)
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before declaring a timeout (range 2..255)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  system clock; controller state updates on posedge; pipeline registers sample enables on negedge
rst_n  in  1  asynchronous active-low reset
id_rs  in  REG_ADDR_W  source register 1 of the instruction in ID
id_rt  in  REG_ADDR_W  source register 2 of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_MemRead  in  1  EX instruction is a load
ex_RegWrite  in  1  EX instruction writes the register file
ex_rd  in  REG_ADDR_W  destination register of the EX instruction
branch_taken  in  1  branch resolved taken in EX this cycle
mem_req  in  1  MEM-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
stall_clr  in  1  synchronous clear of stall_cnt
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
if_id_flush  out  1  IF_ID loads a NOP
id_ex_flush  out  1  ID_EX loads a bubble (all control bits 0)
mem_wb_bubble  out  1  MEM_WB loads MemtoReg=0 with RegWrite cleared
mem_timeout  out  1  sticky timeout error flag
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
state  out  2  RUN=0, MEM_WAIT=1, ERR=2

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0. While rst_n is low, all enables, flushes and bubble are forced to 0.
- Outputs are combinational from the current state and inputs. State and counters update on posedge clk.
- The load_use condition is: ex_MemRead & ex_RegWrite & (ex_rd!=0) & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- RUN evaluates the following in priority order:
  1. mem_req & !mem_ready: all five enables=0, mem_wb_bubble=1. Next state is MEM_WAIT with wait_cnt=1.
  2. branch_taken: all enables=1, if_id_flush=1, id_ex_flush=1. Any simultaneous load_use is ignored because the offending ID instruction is being squashed.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Lasts exactly one cycle, since the load advances to MEM and the condition clears.
  4. Otherwise: all enables=1, no flush, no bubble.
- MEM_WAIT:
  - If mem_ready=0: all enables=0, mem_wb_bubble=1. If wait_cnt==MEM_TIMEOUT, go to ERR and set mem_timeout; otherwise wait_cnt+1.
  - If mem_ready=1: outputs are exactly those of RUN priorities 2–4, evaluated on the held inputs, with mem_wb_en=1 so MEM_WB captures the read data. Next state is RUN and wait_cnt=0.
- ERR: all enables=0, all flushes 0, mem_wb_bubble=1, mem_timeout=1. Exit only via rst_n.
- stall_cnt increments each posedge where pc_en=0 and rst_n=1. It saturates at all-ones. When stall_clr=1 it is cleared to 0, and the clear wins over a simultaneous increment.
- A mem_ready seen in RUN without a preceding wait is a zero-wait access: no stall.
- Asserting rst_n mid-MEM_WAIT aborts the wait immediately. Pipeline state is not preserved.

Test Plan:
- Load-use: ex_MemRead=1, ex_RegWrite=1, ex_rd=3, id_rs=3 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle; stall_cnt 0->1.
- rd=0 / unused rt: ex_rd=0=id_rs, or ex_rd=5=id_rt with id_uses_rt=0 -> no stall, all enables=1.
- Branch plus load-use in the same cycle: branch_taken=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_en=1, no stall.
- Multi-cycle memory: mem_req=1, mem_ready low for 3 cycles then high -> MEM_WAIT for 3 cycles with all enables 0 and mem_wb_bubble=1; the 4th cycle has mem_wb_en=1 and state returns to RUN; stall_cnt=3.
- Timeout: mem_req=1, mem_ready held 0 -> state=ERR and mem_timeout=1 after MEM_TIMEOUT+1 cycles. Both stay set until rst_n pulses low, after which state=RUN and stall_cnt=0.
- Saturation/clear: force 65540 stall cycles -> stall_cnt=16'hFFFF; then stall_clr=1 coincident with a stall cycle -> stall_cnt=0.
